// File: rtl/mod_mul_rt.sv
// mod_mul_rt: Montgomery modular multiplier whose modulus is supplied per request.
//
// Computes z = x*y mod n (mode 0) or the raw Montgomery product x*y*R^-1 mod n
// (mode 1). The modulus n, the digit constant p = -n^-1 mod 2^LOGR and R^2 mod n
// come with each request, so one instance serves any key. The engine is
// digit-serial: one radix-2^LOGR digit of the left operand per clock, followed by
// one conditional-subtract cycle per Montgomery product.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   in_valid / in_ready request handshake (in_ready high only when idle)
//   mode                0: full modular product, 1: raw Montgomery product
//   n, p, r2modn        modulus, -n^-1 mod 2^LOGR, R^2 mod n
//   x, y                operands, each < n
//   out_valid/out_ready result handshake
//   z, err              result; err=1 (z=0) when the request failed input checks
module mod_mul_rt #(
    parameter int N_BIT = 7,
    parameter int LOGR  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [N_BIT-1:0] n,
    input  logic [LOGR-1:0]  p,
    input  logic [N_BIT-1:0] r2modn,
    input  logic [N_BIT-1:0] x,
    input  logic [N_BIT-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_BIT-1:0] z,
    output logic             err
);

    localparam int D  = (N_BIT + LOGR - 1) / LOGR;  // digits per operand
    localparam int AW = D * LOGR;                   // zero-extended operand width
    localparam int PW = N_BIT + LOGR;               // digit x operand product width
    localparam int TW = N_BIT + LOGR + 1;           // accumulator width
    localparam int CW = $clog2(D + 1);
    localparam logic [CW-1:0] CNT_FIX = CW'(D);     // counter value of the fix cycle

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state, state_nx;
    logic             mode_r;
    logic [N_BIT-1:0] n_r, r2_r, x_r, y_r;
    logic [LOGR-1:0]  p_r;
    logic [N_BIT-1:0] xm_r, ym_r, zm_r;   // Montgomery-domain intermediates
    logic [TW-1:0]    t_r;
    logic [CW-1:0]    cnt_r;
    logic [1:0]       op_r;
    logic [N_BIT-1:0] z_r;
    logic             err_r;

    logic             accept, bad_in, fix_cyc, last_op;
    logic [N_BIT-1:0] op_a, op_b;
    logic [LOGR-1:0]  digit, q;
    logic [PW-1:0]    ab, qn;
    logic [TW-1:0]    t_pre, t_sum, t_next;
    logic [N_BIT-1:0] res;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign z         = z_r;
    assign err       = err_r;

    assign accept  = in_valid & in_ready;
    // r2modn only matters when the domain conversion is performed (mode 0).
    assign bad_in  = ~n[0] | (n < N_BIT'(3)) | (x >= n) | (y >= n) |
                     (~mode & (r2modn >= n));
    assign fix_cyc = (cnt_r == CNT_FIX);
    assign last_op = mode_r | (op_r == 2'd3);

    // Operand routing for the op sequence:
    // mode 0: mont(x,R2) -> xm, mont(y,R2) -> ym, mont(xm,ym) -> zm, mont(zm,1) -> z
    // mode 1: mont(x,y) -> z
    always_comb begin
        op_a = '0;
        op_b = '0;
        if (mode_r) begin
            op_a = x_r;
            op_b = y_r;
        end else begin
            case (op_r)
                2'd0:    begin op_a = x_r;  op_b = r2_r;      end
                2'd1:    begin op_a = y_r;  op_b = r2_r;      end
                2'd2:    begin op_a = xm_r; op_b = ym_r;      end
                default: begin op_a = zm_r; op_b = N_BIT'(1); end
            endcase
        end
    end

    // One Montgomery digit step. T stays below 2n, so T + a_i*b + q*n stays
    // below 2*r*n and fits in TW bits; the shift brings it back under 2n.
    // During the fix cycle the shift runs past the operand and digit reads 0.
    assign digit  = LOGR'(AW'(op_a) >> (int'(cnt_r) * LOGR));
    assign ab     = PW'(digit) * PW'(op_b);
    assign t_pre  = t_r + TW'(ab);
    assign q      = LOGR'(t_pre[LOGR-1:0] * p_r);
    assign qn     = PW'(q) * PW'(n_r);
    assign t_sum  = t_pre + TW'(qn);
    assign t_next = t_sum >> LOGR;
    // Final conditional subtract; T < 2n so one subtraction is enough.
    assign res    = (t_r >= TW'(n_r)) ? N_BIT'(t_r - TW'(n_r)) : N_BIT'(t_r);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = bad_in ? DONE : CALC;
                end
            end
            CALC: begin
                if (fix_cyc && last_op) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_r <= 1'b0;
            n_r    <= '0;
            p_r    <= '0;
            r2_r   <= '0;
            x_r    <= '0;
            y_r    <= '0;
            xm_r   <= '0;
            ym_r   <= '0;
            zm_r   <= '0;
            t_r    <= '0;
            cnt_r  <= '0;
            op_r   <= '0;
            z_r    <= '0;
            err_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mode_r <= mode;
                        n_r    <= n;
                        p_r    <= p;
                        r2_r   <= r2modn;
                        x_r    <= x;
                        y_r    <= y;
                        t_r    <= '0;
                        cnt_r  <= '0;
                        op_r   <= '0;
                        if (bad_in) begin
                            z_r   <= '0;
                            err_r <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    if (!fix_cyc) begin
                        t_r   <= t_next;
                        cnt_r <= cnt_r + CW'(1);
                    end else begin
                        t_r   <= '0;
                        cnt_r <= '0;
                        op_r  <= op_r + 2'd1;
                        if (last_op) begin
                            z_r   <= res;
                            err_r <= 1'b0;
                        end else begin
                            case (op_r)
                                2'd0:    xm_r <= res;
                                2'd1:    ym_r <= res;
                                default: zm_r <= res;
                            endcase
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_mul_rt.sv
// Bench for mod_mul_rt: three instances (7/3, 16/4, 16/5) share one stimulus
// bus; sel chooses which instance is driven and observed.
module tb_mod_mul_rt;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, mode, out_ready;
    logic [15:0] n_b, r2_b, x_b, y_b;
    logic [4:0]  p_b;
    int          sel;

    logic        iv0, iv1, iv2;
    logic        rdy0, rdy1, rdy2, ov0, ov1, ov2, err0, err1, err2;
    logic [6:0]  z0;
    logic [15:0] z1, z2;

    logic        rdy_m, ov_m, err_m;
    logic [15:0] z_m;

    int tests = 0;
    int fails = 0;

    assign iv0 = in_valid && (sel == 0);
    assign iv1 = in_valid && (sel == 1);
    assign iv2 = in_valid && (sel == 2);

    mod_mul_rt #(.N_BIT(7), .LOGR(3)) u0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(rdy0), .mode(mode),
        .n(n_b[6:0]), .p(p_b[2:0]), .r2modn(r2_b[6:0]), .x(x_b[6:0]), .y(y_b[6:0]),
        .out_valid(ov0), .out_ready(out_ready), .z(z0), .err(err0));

    mod_mul_rt #(.N_BIT(16), .LOGR(4)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(rdy1), .mode(mode),
        .n(n_b), .p(p_b[3:0]), .r2modn(r2_b), .x(x_b), .y(y_b),
        .out_valid(ov1), .out_ready(out_ready), .z(z1), .err(err1));

    mod_mul_rt #(.N_BIT(16), .LOGR(5)) u2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(rdy2), .mode(mode),
        .n(n_b), .p(p_b), .r2modn(r2_b), .x(x_b), .y(y_b),
        .out_valid(ov2), .out_ready(out_ready), .z(z2), .err(err2));

    always_comb begin
        case (sel)
            1:       begin rdy_m = rdy1; ov_m = ov1; z_m = z1;          err_m = err1; end
            2:       begin rdy_m = rdy2; ov_m = ov2; z_m = z2;          err_m = err2; end
            default: begin rdy_m = rdy0; ov_m = ov0; z_m = {9'd0, z0}; err_m = err0; end
        endcase
    end

    function automatic int nbit_of(input int s);
        return (s == 0) ? 7 : 16;
    endfunction

    function automatic int logr_of(input int s);
        return (s == 0) ? 3 : ((s == 1) ? 4 : 5);
    endfunction

    // Reference: plain modular arithmetic. R^-1 is applied as repeated
    // division by two modulo n (add n when odd, then halve).
    // Latency is edges after the accept edge; a rejected request is already
    // in DONE right after the accept edge.
    function automatic longint ref_model(input int s, input logic m, input longint nn,
                                         input longint rr, input longint xx, input longint yy,
                                         output logic e, output int lat);
        int     lr, d;
        longint v;
        lr = logr_of(s);
        d  = (nbit_of(s) + lr - 1) / lr;
        e  = (nn % 2 == 0) || (nn < 3) || (xx >= nn) || (yy >= nn) || (!m && rr >= nn);
        if (e) begin
            lat = 0;
            return 0;
        end
        v = (xx * yy) % nn;
        if (m) begin
            for (int i = 0; i < lr * d; i++) begin
                if (v % 2 == 1) v = v + nn;
                v = v / 2;
            end
            lat = d + 1;
        end else begin
            lat = 4 * (d + 1);
        end
        return v;
    endfunction

    task automatic check(input string nm, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic send(input logic m, input int nn, input int pp, input int rr,
                        input int xx, input int yy);
        int w;
        w = 0;
        @(negedge clk);
        while (!rdy_m && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!rdy_m) check("in_ready_timeout", 0, 1);
        mode     = m;
        n_b      = 16'(nn);
        p_b      = 5'(pp);
        r2_b     = 16'(rr);
        x_b      = 16'(xx);
        y_b      = 16'(yy);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!ov_m && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input string nm, input logic m, input int nn, input int pp,
                          input int rr, input int xx, input int yy,
                          input int ez, input logic ee, input int el);
        int lat;
        send(m, nn, pp, rr, xx, yy);
        wait_out(lat);
        check({nm, "_lat"}, lat, el);
        check({nm, "_z"}, z_m, ez);
        check({nm, "_err"}, err_m, ee);
        @(posedge clk);
        #1;
        check({nm, "_release"}, ov_m, 0);
    endtask

    typedef struct {
        string name;
        logic  m;
        int    n;
        int    r2;
        int    x;
        int    y;
        int    z;
        logic  e;
        int    lat;
    } vec_t;

    vec_t vt[10];

    initial begin
        int          lat, ez, el, nb, lr, d, pp, nn, xx, yy, rr;
        logic        ee, mm;
        longint      big_r;

        vt[0] = '{"m0_5x20",     1'b0, 79, 22,  5, 20, 21, 1'b0, 16};
        vt[1] = '{"m1_5x20",     1'b1, 79, 22,  5, 20, 65, 1'b0, 4};
        vt[2] = '{"m0_78x78",    1'b0, 79, 22, 78, 78,  1, 1'b0, 16};
        vt[3] = '{"m0_0x55",     1'b0, 79, 22,  0, 55,  0, 1'b0, 16};
        vt[4] = '{"m0_1x1",      1'b0, 79, 22,  1,  1,  1, 1'b0, 16};
        vt[5] = '{"m0_3x4",      1'b0, 79, 22,  3,  4, 12, 1'b0, 16};
        vt[6] = '{"rej_x_eq_n",  1'b0, 79, 22, 79, 20,  0, 1'b1, 0};
        vt[7] = '{"rej_n_even",  1'b0, 78, 22,  5, 20,  0, 1'b1, 0};
        vt[8] = '{"rej_r2_big",  1'b0, 79, 79,  5, 20,  0, 1'b1, 0};
        vt[9] = '{"m1_r2_big_ok",1'b1, 79, 79,  5, 20, 65, 1'b0, 4};

        rst = 1'b1; in_valid = 1'b0; mode = 1'b0; out_ready = 1'b1; sel = 0;
        n_b = '0; p_b = '0; r2_b = '0; x_b = '0; y_b = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_in_ready", rdy_m, 1);
        check("reset_out_valid", ov_m, 0);
        check("reset_z", z_m, 0);
        check("reset_err", err_m, 0);
        check("reset_in_ready_u1", rdy1, 1);
        check("reset_in_ready_u2", rdy2, 1);

        for (int i = 0; i < 10; i++)
            run_op(vt[i].name, vt[i].m, vt[i].n, 1, vt[i].r2, vt[i].x, vt[i].y,
                   vt[i].z, vt[i].e, vt[i].lat);

        // Backpressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        send(1'b0, 79, 1, 22, 5, 20);
        wait_out(lat);
        check("bp_lat", lat, 16);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", ov_m, 1);
            check("bp_hold_z", z_m, 21);
            check("bp_hold_in_ready", rdy_m, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release", ov_m, 0);
        check("bp_idle", rdy_m, 1);
        check("bp_z_kept", z_m, 21);
        run_op("bp_next", 1'b0, 79, 1, 22, 3, 4, 12, 1'b0, 16);

        // Reset at edge 7 of a mode 0 request aborts it.
        send(1'b0, 79, 1, 22, 5, 20);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_in_ready", rdy_m, 1);
        check("abort_out_valid", ov_m, 0);
        check("abort_z", z_m, 0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (ov_m) check("abort_no_result", ov_m, 0);
        end
        run_op("abort_next", 1'b0, 79, 1, 22, 3, 4, 12, 1'b0, 16);

        // Random sweep against the reference model on all three geometries.
        for (int s = 0; s < 3; s++) begin
            sel = s;
            nb  = nbit_of(s);
            lr  = logr_of(s);
            d   = (nb + lr - 1) / lr;
            big_r = longint'(1) << (lr * d);
            for (int k = 0; k < 30; k++) begin
                nn = int'($urandom % ((32'd1 << nb) - 32'd3)) + 3;
                nn = nn | 1;
                pp = 0;
                for (int c = 0; c < (1 << lr); c++)
                    if ((longint'(nn) * c + 1) % (longint'(1) << lr) == 0) pp = c;
                rr = int'(((big_r % nn) * (big_r % nn)) % nn);
                xx = int'($urandom % nn);
                yy = int'($urandom % nn);
                if ($urandom % 8 == 0) xx = nn;
                mm = 1'($urandom % 2);
                ez = int'(ref_model(s, mm, nn, rr, xx, yy, ee, el));
                run_op($sformatf("rnd_s%0d_k%0d", s, k), mm, nn, pp, rr, xx, yy, ez, ee, el);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
